nmcu_instr_arbiter: RTL and testbench

Round-robin arbiter that lets NUM_REQ CPU-side requesters share the single NMCU instruction/response port. It allows one outstanding instruction at a time and routes each response back to the requester that issued it. A response watchdog returns an error to the requester if the NMCU does not answer in time. It sits between the host-side requester ports and the nmcu top-level instruction/response interface.

---
 rtl/nmcu_instr_arbiter_pkg.sv | 37 +++
 rtl/nmcu_instr_arbiter_rr_arbiter.sv | 40 ++++
 rtl/nmcu_instr_arbiter.sv | 151 +++++++++++++++
 tb/tb_nmcu_instr_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmcu_instr_arbiter_pkg.sv
// rtl/nmcu_instr_arbiter_pkg.sv - shared types for the NMCU instruction arbiter
//
// Purpose: instruction and response payload types shared with the NMCU top
// level, the arbiter FSM state type and the arbiter-reserved status code.
// Ports: none (package).
package nmcu_instr_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_ADD   = 2'b11
    } opcode_t;

    typedef struct packed {
        opcode_t     op;
        logic [7:0]  addr;
        logic [15:0] data;
    } instruction_t;

    typedef struct packed {
        logic [1:0]  status;
        logic [15:0] data;
    } nmcu_cpu_resp_t;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    // Never produced by the NMCU; only the arbiter watchdog uses it.
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        WAIT   = 2'b10,
        RETURN = 2'b11
    } arb_state_t;

endpackage

// File: rtl/nmcu_instr_arbiter_rr_arbiter.sv
// rtl/nmcu_instr_arbiter_rr_arbiter.sv - combinational round-robin priority search
//
// Purpose: picks the first valid requester at or after ptr, wrapping modulo
// NUM_REQ.
// Ports:
//   valid - per-requester request vector
//   ptr   - round-robin start index (must be < NUM_REQ)
//   grant - one-hot grant, zero when nothing is valid
//   idx   - index of the granted requester
//   any   - at least one requester is valid
module nmcu_instr_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest valid index to
    // ptr is the last one written and therefore wins.
    always_comb begin
        cand = 0;
        idx  = '0;
        any  = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (valid[cand]) begin
                idx = IW'(cand);
                any = 1'b1;
            end
        end
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/nmcu_instr_arbiter.sv
// rtl/nmcu_instr_arbiter.sv - round-robin arbiter for the shared NMCU instruction port
//
// Purpose: shares one NMCU instruction/response port among NUM_REQ requesters,
// one outstanding instruction at a time, with a response watchdog.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_valid_i/instr_i  - requester instructions; req_ready_o one-hot accept
//   resp_valid_o/ready_i - one-hot response handshake; resp_o shared payload
//   nmcu_instr_*         - instruction handshake towards the NMCU
//   nmcu_resp_*          - response handshake from the NMCU
//   owner_o              - current/last granted requester
//   busy_o               - transaction in flight or stale response pending
//   err_cnt_o            - saturating watchdog timeout count
module nmcu_instr_arbiter
    import nmcu_instr_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  instruction_t [NUM_REQ-1:0] req_instr_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    input  logic [NUM_REQ-1:0]       resp_ready_i,
    output nmcu_cpu_resp_t           resp_o,
    output logic                     nmcu_instr_valid_o,
    output instruction_t             nmcu_instr_o,
    input  logic                     nmcu_instr_ready_i,
    input  logic                     nmcu_resp_valid_i,
    output logic                     nmcu_resp_ready_o,
    input  nmcu_cpu_resp_t           nmcu_resp_i,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                     busy_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t         state, state_next;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      owner;
    logic               stale;
    logic [TW-1:0]      timer;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    instruction_t       instr_q;
    nmcu_cpu_resp_t     resp_q;

    logic [NUM_REQ-1:0] win_grant;
    logic [IW-1:0]      win_idx;
    logic               win_any;
    logic               timeout_hit;

    nmcu_instr_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_any && !stale)           state_next = ISSUE;
            ISSUE:   if (nmcu_instr_ready_i)          state_next = WAIT;
            WAIT:    if (nmcu_resp_valid_i || timeout_hit) state_next = RETURN;
            RETURN:  if (resp_ready_i[owner])         state_next = IDLE;
            default:                                  state_next = IDLE;
        endcase
    end

    // Handshake outputs are forced low while rst is high, because the state
    // register only returns to IDLE on the reset edge itself.
    always_comb begin
        req_ready_o        = '0;
        resp_valid_o       = '0;
        nmcu_instr_valid_o = 1'b0;
        nmcu_resp_ready_o  = 1'b0;
        if (!rst) begin
            if (state == IDLE && !stale) req_ready_o = win_grant;
            if (state == RETURN)         resp_valid_o = NUM_REQ'(1) << owner;
            nmcu_instr_valid_o = (state == ISSUE);
            // A stale response after a timeout must be drained whatever the FSM does.
            nmcu_resp_ready_o  = (state == WAIT) || stale;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            owner   <= '0;
            stale   <= 1'b0;
            timer   <= '0;
            err_cnt <= '0;
            instr_q <= '0;
            resp_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any && !stale) begin
                        instr_q <= req_instr_i[win_idx];
                        owner   <= win_idx;
                        rr_ptr  <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    end
                end
                ISSUE: begin
                    if (nmcu_instr_ready_i) timer <= '0;
                end
                WAIT: begin
                    // A response in the timeout cycle wins over the watchdog.
                    if (nmcu_resp_valid_i) begin
                        resp_q <= nmcu_resp_i;
                    end else if (timeout_hit) begin
                        resp_q <= '{status: STATUS_TIMEOUT, data: 16'h0};
                        stale  <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
            // The late answer to a timed-out instruction is swallowed here.
            if (stale && nmcu_resp_valid_i) stale <= 1'b0;
        end
    end

    assign nmcu_instr_o = instr_q;
    assign resp_o       = resp_q;
    assign owner_o      = owner;
    assign busy_o       = (state != IDLE) || stale;
    assign err_cnt_o    = err_cnt;

endmodule

// File: tb/tb_nmcu_instr_arbiter.sv
// tb/tb_nmcu_instr_arbiter.sv - self-checking bench for nmcu_instr_arbiter
module tb_nmcu_instr_arbiter;
    import nmcu_instr_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int TO = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       req_valid_i = '0;
    instruction_t [NR-1:0] req_instr_i = '0;
    logic [NR-1:0]       req_ready_o;
    logic [NR-1:0]       resp_valid_o;
    logic [NR-1:0]       resp_ready_i = '0;
    nmcu_cpu_resp_t      resp_o;
    logic                nmcu_instr_valid_o;
    instruction_t        nmcu_instr_o;
    logic                nmcu_instr_ready_i = 1'b0;
    logic                nmcu_resp_valid_i = 1'b0;
    logic                nmcu_resp_ready_o;
    nmcu_cpu_resp_t      nmcu_resp_i = '0;
    logic [0:0]          owner_o;
    logic                busy_o;
    logic [7:0]          err_cnt_o;

    nmcu_instr_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_instr_i(req_instr_i), .req_ready_o(req_ready_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
        .nmcu_instr_valid_o(nmcu_instr_valid_o), .nmcu_instr_o(nmcu_instr_o),
        .nmcu_instr_ready_i(nmcu_instr_ready_i), .nmcu_resp_valid_i(nmcu_resp_valid_i),
        .nmcu_resp_ready_o(nmcu_resp_ready_o), .nmcu_resp_i(nmcu_resp_i),
        .owner_o(owner_o), .busy_o(busy_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { int req; instruction_t instr; nmcu_cpu_resp_t exp; } vec_t;
    typedef struct { int req; nmcu_cpu_resp_t exp; } sb_t;

    vec_t   rq0[$];
    vec_t   rq1[$];
    sb_t    sb[$];
    int     grant_log[$];
    vec_t   vecs[4];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int issue_due = -1, resp_due = -1, drop_due = -1;
    int issue_cyc = -1, first_rv = -1;
    logic rst_drv = 1'b1;
    logic [NR-1:0] rr_mask = '1;
    logic mute = 1'b0;
    logic has_pend = 1'b0;
    int   pend_cnt = 0;
    nmcu_cpu_resp_t pend_resp = '0;
    logic exp_stale = 1'b0;
    instruction_t last_instr = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mkv(int req, opcode_t op, int addr, int data, logic [1:0] st, int edata);
        vec_t v;
        v.req = req;
        v.instr.op = op;
        v.instr.addr = 8'(addr);
        v.instr.data = 16'(data);
        v.exp.status = st;
        v.exp.data = 16'(edata);
        return v;
    endfunction

    // Stand-in NMCU behaviour: STORE answers 0, LOAD/ADD answer data+addr,
    // ADD reports status 01 to exercise status pass-through.
    function automatic nmcu_cpu_resp_t nmcu_model(instruction_t in);
        nmcu_cpu_resp_t r;
        r.status = (in.op == OP_ADD) ? 2'b01 : 2'b00;
        r.data   = (in.op == OP_STORE) ? 16'h0 : in.data + 16'(in.addr);
        return r;
    endfunction

    task automatic enq(vec_t v);
        if (v.req == 0) rq0.push_back(v); else rq1.push_back(v);
    endtask

    task automatic tick();
        logic [NR-1:0] acc;
        vec_t e;
        sb_t  s;
        int   idx;
        @(negedge clk);
        rst = rst_drv;
        req_valid_i[0] = (rq0.size() > 0);
        req_valid_i[1] = (rq1.size() > 0);
        req_instr_i[0] = (rq0.size() > 0) ? rq0[0].instr : '0;
        req_instr_i[1] = (rq1.size() > 0) ? rq1[0].instr : '0;
        resp_ready_i = rr_mask;
        nmcu_instr_ready_i = 1'b1;
        nmcu_resp_valid_i = 1'b0;
        nmcu_resp_i = '0;
        if (has_pend) begin
            if (pend_cnt == 0) begin
                nmcu_resp_valid_i = 1'b1;
                nmcu_resp_i = pend_resp;
            end else begin
                pend_cnt--;
            end
        end
        #1;
        if (!rst) begin
            if (issue_due == cyc) begin
                check("issue_valid", 64'(nmcu_instr_valid_o), 64'd1);
                check("issue_instr", 64'(nmcu_instr_o), 64'(last_instr));
            end
            if (resp_due == cyc) check("resp_latency", 64'(resp_valid_o != 0), 64'd1);
            if (drop_due == cyc) check("stale_dropped", 64'(resp_valid_o), 64'd0);
            if (exp_stale) check("stale_resp_ready", 64'(nmcu_resp_ready_o), 64'd1);

            acc = req_valid_i & req_ready_o;
            if (acc != 0) begin
                check("accept_onehot", 64'($countones(acc)), 64'd1);
                idx = acc[0] ? 0 : 1;
                if (idx == 0) e = rq0.pop_front(); else e = rq1.pop_front();
                s.req = idx;
                s.exp = e.exp;
                sb.push_back(s);
                grant_log.push_back(idx);
                last_instr = e.instr;
                issue_due = cyc + 1;
            end

            if (nmcu_instr_valid_o && nmcu_instr_ready_i) begin
                issue_cyc = cyc;
                if (!mute) begin
                    has_pend = 1'b1;
                    pend_cnt = 2;
                    pend_resp = nmcu_model(nmcu_instr_o);
                end
            end

            if (nmcu_resp_valid_i && nmcu_resp_ready_o) begin
                has_pend = 1'b0;
                if (exp_stale) begin
                    exp_stale = 1'b0;
                    drop_due = cyc + 1;
                end else begin
                    resp_due = cyc + 1;
                end
            end

            if (resp_valid_o != 0) begin
                if (first_rv < 0) first_rv = cyc;
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid_o), 64'd0);
                end else begin
                    check("resp_route", 64'(resp_valid_o), 64'(2'b01 << sb[0].req));
                    check("owner", 64'(owner_o), 64'(sb[0].req));
                    if ((resp_valid_o & resp_ready_i) != 0) begin
                        s = sb.pop_front();
                        check("resp_status", 64'(resp_o.status), 64'(s.exp.status));
                        check("resp_data", 64'(resp_o.data), 64'(s.exp.data));
                        if (s.exp.status == STATUS_TIMEOUT) exp_stale = 1'b1;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0;
        rq0.delete();
        rq1.delete();
        sb.delete();
        grant_log.delete();
        has_pend = 1'b0;
        exp_stale = 1'b0;
        issue_due = -1;
        resp_due = -1;
        drop_due = -1;
        issue_cyc = -1;
        first_rv = -1;
    endtask

    task automatic run_until_idle(string name, int budget);
        int n;
        n = 0;
        while (!(rq0.size() == 0 && rq1.size() == 0 && sb.size() == 0 && !has_pend && !busy_o)) begin
            if (n >= budget) begin
                tests++;
                fails++;
                $display("FAIL %s: timeout after %0d cycles, still busy", name, budget);
                return;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        vecs[0] = mkv(0, OP_LOAD, 1, 10, 2'b00, 11);
        vecs[1] = mkv(1, OP_LOAD, 2, 20, 2'b00, 22);
        vecs[2] = mkv(0, OP_LOAD, 5, 30, 2'b00, 35);
        vecs[3] = mkv(1, OP_ADD,  6, 40, 2'b01, 46);

        // Reset state
        do_reset();
        tick();
        check("rst_owner", 64'(owner_o), 64'd0);
        check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_instr_valid", 64'(nmcu_instr_valid_o), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_instr", 64'(nmcu_instr_o), 64'd0);

        // Single requester STORE
        enq(mkv(0, OP_STORE, 3, 7, 2'b00, 0));
        run_until_idle("single_store", 50);

        // Contention: strict alternation from a fresh reset
        do_reset();
        for (int k = 0; k < 4; k++) enq(vecs[k]);
        run_until_idle("contention", 200);
        check("grant_count", 64'(grant_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check("grant_order", 64'(grant_log[k]), 64'(vecs[k].req));

        // Response backpressure on requester 1
        do_reset();
        rr_mask = 2'b01;
        enq(mkv(1, OP_LOAD, 4, 15, 2'b00, 19));
        for (int n = 0; n < 30 && resp_valid_o[1] !== 1'b1; n++) tick();
        check("bp_reached_return", 64'(resp_valid_o), 64'b10);
        enq(mkv(0, OP_STORE, 1, 1, 2'b00, 0));
        for (int n = 0; n < 5; n++) begin
            tick();
            check("bp_hold_valid", 64'(resp_valid_o), 64'b10);
            check("bp_hold_data", 64'(resp_o), 64'({2'b00, 16'd19}));
            check("bp_no_grant", 64'(req_ready_o), 64'd0);
        end
        rr_mask = 2'b11;
        run_until_idle("backpressure", 60);

        // Watchdog timeout, then stale drop
        do_reset();
        mute = 1'b1;
        enq(mkv(0, OP_LOAD, 7, 8, STATUS_TIMEOUT, 0));
        enq(mkv(1, OP_LOAD, 3, 30, 2'b00, 33));
        for (int n = 0; n < 60 && first_rv < 0; n++) tick();
        check("timeout_latency", 64'(first_rv - issue_cyc), 64'(TO + 1));
        tick();
        check("timeout_err_cnt", 64'(err_cnt_o), 64'd1);
        check("timeout_busy", 64'(busy_o), 64'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("stale_blocks_grant", 64'(req_ready_o), 64'd0);
            check("stale_busy", 64'(busy_o), 64'd1);
        end
        mute = 1'b0;
        has_pend = 1'b1;
        pend_cnt = 0;
        pend_resp = '{status: 2'b00, data: 16'd22};
        run_until_idle("stale_drop", 60);
        check("stale_then_grant", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) check("stale_grant_req1", 64'(grant_log[1]), 64'd1);

        // Reset in the middle of WAIT
        mute = 1'b1;
        grant_log.delete();
        enq(mkv(0, OP_LOAD, 1, 1, 2'b00, 2));
        for (int n = 0; n < 20 && issue_cyc < 0; n++) tick();
        for (int n = 0; n < 3; n++) tick();
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        do_reset();
        check("midrst_req_ready", 64'(req_ready_o), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("midrst_instr_valid", 64'(nmcu_instr_valid_o), 64'd0);
        check("midrst_resp_ready", 64'(nmcu_resp_ready_o), 64'd0);
        mute = 1'b0;
        tick();
        check("midrst_owner", 64'(owner_o), 64'd0);
        check("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        enq(mkv(1, OP_LOAD, 2, 2, 2'b00, 4));
        enq(mkv(0, OP_LOAD, 3, 3, 2'b00, 6));
        run_until_idle("post_reset", 60);
        check("post_rst_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 0) check("post_rst_first_grant", 64'(grant_log[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
